// File: rtl/i2c_write_master_if.sv
// Request/status bundle between the init sequencer (master side) and the
// I2C write master (slave side).
interface i2c_write_master_if #(
   parameter int MAX_BYTES = 2,
   parameter int CNT_W     = 2
);
   logic                   START;
   logic [6:0]             SLAVE_ADDR;
   logic [CNT_W-1:0]       NUM_BYTES;
   logic [8*MAX_BYTES-1:0] DATA;
   logic                   BUSY;
   logic                   DONE;
   logic                   ACK_ERR;

   modport master (output START, SLAVE_ADDR, NUM_BYTES, DATA,
                   input  BUSY, DONE, ACK_ERR);
   modport slave  (input  START, SLAVE_ADDR, NUM_BYTES, DATA,
                   output BUSY, DONE, ACK_ERR);
endinterface

// File: rtl/i2c_write_master.sv
// Write-only I2C master: START, {addr,W}, 0..MAX_BYTES data bytes, STOP.
// SCL is a divided MCLK; every ACK slot is checked and a NACK aborts to STOP.
module i2c_write_master #(
   parameter int CLK_DIV   = 4,
   parameter int MAX_BYTES = 2,
   parameter int CNT_W     = 2
) (
   input  logic              MCLK,
   input  logic              RESET,
   i2c_write_master_if.slave ctl,
   output logic              SCL,
   inout  wire               SDA
);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int PW    = 8 * MAX_BYTES;

   typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP} state_t;

   state_t           state;
   logic [DIV_W-1:0] div_cnt;
   logic [1:0]       q;
   logic [2:0]       bit_idx;
   logic [7:0]       sh;
   logic [PW-1:0]    payload;
   logic [CNT_W-1:0] bytes_left;
   logic [CNT_W-1:0] n_req;
   logic             sda_oe;
   logic             sda_meta;
   logic             sda_sync;
   logic             busy;
   logic             done;
   logic             ack_err;
   logic             tick;

   assign tick  = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign n_req = (ctl.NUM_BYTES > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : ctl.NUM_BYTES;

   assign SDA         = sda_oe ? 1'b0 : 1'bz;
   assign ctl.BUSY    = busy;
   assign ctl.DONE    = done;
   assign ctl.ACK_ERR = ack_err;

   always_ff @(posedge MCLK or negedge RESET) begin
      if (!RESET) begin
         sda_meta <= 1'b1;
         sda_sync <= 1'b1;
      end else begin
         sda_meta <= SDA;
         sda_sync <= sda_meta;
      end
   end

   always_ff @(posedge MCLK or negedge RESET) begin
      if (!RESET) begin
         state      <= S_IDLE;
         div_cnt    <= '0;
         q          <= 2'd0;
         bit_idx    <= 3'd0;
         sh         <= 8'd0;
         payload    <= '0;
         bytes_left <= '0;
         SCL        <= 1'b1;
         sda_oe     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         ack_err    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == S_IDLE) div_cnt <= '0;
         else                 div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);

         case (state)
            S_IDLE: if (ctl.START) begin
               state      <= S_START;
               q          <= 2'd0;
               busy       <= 1'b1;
               ack_err    <= 1'b0;
               bit_idx    <= 3'd0;
               sh         <= {ctl.SLAVE_ADDR, 1'b0};
               // Left-align so the first byte sent is always the top byte.
               payload    <= ctl.DATA << (8 * (MAX_BYTES - int'(n_req)));
               bytes_left <= n_req;
               SCL        <= 1'b1;
               sda_oe     <= 1'b1;
            end

            S_START: if (tick) begin
               if (q == 2'd0) begin
                  q   <= 2'd1;
                  SCL <= 1'b0;
               end else begin
                  state  <= S_BIT;
                  q      <= 2'd0;
                  sda_oe <= ~sh[7];
               end
            end

            S_BIT: if (tick) begin
               case (q)
                  2'd0: begin q <= 2'd1; SCL <= 1'b1; end
                  2'd1: q <= 2'd2;
                  2'd2: begin q <= 2'd3; SCL <= 1'b0; end
                  default: begin
                     q <= 2'd0;
                     if (bit_idx == 3'd7) begin
                        state  <= S_ACK;
                        sda_oe <= 1'b0;
                     end else begin
                        bit_idx <= bit_idx + 3'd1;
                        sh      <= {sh[6:0], 1'b0};
                        sda_oe  <= ~sh[6];
                     end
                  end
               endcase
            end

            S_ACK: if (tick) begin
               case (q)
                  2'd0: begin q <= 2'd1; SCL <= 1'b1; end
                  2'd1: q <= 2'd2;
                  2'd2: begin
                     q   <= 2'd3;
                     SCL <= 1'b0;
                     if (sda_sync) ack_err <= 1'b1;
                  end
                  default: begin
                     q <= 2'd0;
                     if (ack_err || bytes_left == '0) begin
                        state  <= S_STOP;
                        sda_oe <= 1'b1;
                     end else begin
                        state      <= S_BIT;
                        bit_idx    <= 3'd0;
                        sh         <= payload[PW-1 -: 8];
                        payload    <= payload << 8;
                        bytes_left <= bytes_left - CNT_W'(1);
                        sda_oe     <= ~payload[PW-1];
                     end
                  end
               endcase
            end

            S_STOP: if (tick) begin
               case (q)
                  2'd0: begin q <= 2'd1; SCL <= 1'b1; end
                  2'd1: begin q <= 2'd2; sda_oe <= 1'b0; end
                  default: begin
                     q     <= 2'd0;
                     state <= S_IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               endcase
            end

            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: bus monitor + ACKing slave model, expected bytes
// queued at launch and compared as each byte appears on SDA.
module tb_i2c_write_master;
   localparam int CLK_DIV   = 4;
   localparam int MAX_BYTES = 2;
   localparam int CNT_W     = 2;

   logic mclk = 1'b0;
   logic reset_n;
   logic scl;
   wire  sda;

   pullup (sda);

   i2c_write_master_if #(.MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) ctl ();

   i2c_write_master #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) dut (
      .MCLK  (mclk),
      .RESET (reset_n),
      .ctl   (ctl),
      .SCL   (scl),
      .SDA   (sda)
   );

   always #5 mclk = ~mclk;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;
   logic [7:0] sh_mon   = 8'd0;
   int         starts   = 0;
   int         stops    = 0;
   int         bitn     = 0;
   int         byte_idx = 0;
   int         bytes_seen = 0;
   logic       in_frame  = 1'b0;
   logic       nack_addr = 1'b0;
   logic       ack_drv   = 1'b0;

   assign sda = ack_drv ? 1'b0 : 1'bz;

   always @(negedge sda) if (scl === 1'b1) begin
      starts++;
      in_frame = 1'b1;
      bitn     = 0;
      byte_idx = 0;
   end

   always @(posedge sda) if (scl === 1'b1) begin
      stops++;
      in_frame = 1'b0;
   end

   always @(posedge scl) if (in_frame) begin
      if (bitn < 8) sh_mon = {sh_mon[6:0], sda};
      bitn++;
      if (bitn == 8) begin
         bytes_seen++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sda_byte got=%02h expected=none", sh_mon);
         end else begin
            mon_exp = exp_q.pop_front();
            if (sh_mon !== mon_exp) begin
               failures++;
               $display("FAIL sda_byte got=%02h expected=%02h", sh_mon, mon_exp);
            end
         end
      end
   end

   // Slave answers the ninth clock; optionally refuses the address.
   always @(negedge scl) if (in_frame) begin
      if (bitn == 8) ack_drv = !(nack_addr && byte_idx == 0);
      else if (bitn == 9) begin
         ack_drv = 1'b0;
         bitn    = 0;
         byte_idx++;
      end
   end

   task automatic launch(input logic [6:0] a, input logic [CNT_W-1:0] n, input logic [15:0] d);
      ctl.SLAVE_ADDR = a;
      ctl.NUM_BYTES  = n;
      ctl.DATA       = d;
      ctl.START      = 1'b1;
      @(posedge mclk); #1;
      ctl.START = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int cyc);
      cyc = -1;
      for (int i = 1; i <= limit; i++) begin
         @(posedge mclk); #1;
         if (ctl.DONE === 1'b1) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n        = 1'b0;
      ctl.START      = 1'b0;
      ctl.SLAVE_ADDR = 7'd0;
      ctl.NUM_BYTES  = '0;
      ctl.DATA       = 16'd0;
      repeat (3) @(posedge mclk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge mclk); #1;
         checks++;
         if ({scl, sda, ctl.BUSY, ctl.DONE, ctl.ACK_ERR} !== 5'b11000) begin
            failures++;
            $display("FAIL reset_idle cycle=%0d got=%b expected=11000", i,
                     {scl, sda, ctl.BUSY, ctl.DONE, ctl.ACK_ERR});
         end
      end
   endtask

   task automatic test_write();
      int cyc, s0, p0, b0;
      nack_addr = 1'b0;
      s0 = starts; p0 = stops; b0 = bytes_seen;
      exp_q.push_back(8'h34); exp_q.push_back(8'h1E); exp_q.push_back(8'h00);
      launch(7'h1A, 2'd2, 16'h1E00);
      checks++;
      if (ctl.BUSY !== 1'b1) begin failures++; $display("FAIL write_busy got=%b expected=1", ctl.BUSY); end
      wait_done(2000, cyc);
      checks++;
      if (cyc !== 452) begin failures++; $display("FAIL write_latency got=%0d expected=452", cyc); end
      checks++;
      if (ctl.ACK_ERR !== 1'b0) begin failures++; $display("FAIL write_ack_err got=%b expected=0", ctl.ACK_ERR); end
      @(posedge mclk); #1;
      checks++;
      if ({ctl.DONE, ctl.BUSY} !== 2'b00) begin
         failures++; $display("FAIL write_done_pulse got=%b expected=00", {ctl.DONE, ctl.BUSY});
      end
      checks++;
      if (starts - s0 !== 1 || stops - p0 !== 1 || bytes_seen - b0 !== 3 || exp_q.size() !== 0) begin
         failures++;
         $display("FAIL write_framing got=%0d/%0d/%0d/%0d expected=1/1/3/0",
                  starts - s0, stops - p0, bytes_seen - b0, exp_q.size());
      end
   endtask

   task automatic test_nack();
      int cyc, s0, p0, b0;
      nack_addr = 1'b1;
      s0 = starts; p0 = stops; b0 = bytes_seen;
      exp_q.push_back(8'h34);
      launch(7'h1A, 2'd2, 16'h1E00);
      wait_done(2000, cyc);
      checks++;
      if (cyc !== 164) begin failures++; $display("FAIL nack_latency got=%0d expected=164", cyc); end
      checks++;
      if (ctl.ACK_ERR !== 1'b1) begin failures++; $display("FAIL nack_ack_err got=%b expected=1", ctl.ACK_ERR); end
      checks++;
      if (starts - s0 !== 1 || stops - p0 !== 1 || bytes_seen - b0 !== 1 || exp_q.size() !== 0) begin
         failures++;
         $display("FAIL nack_framing got=%0d/%0d/%0d/%0d expected=1/1/1/0",
                  starts - s0, stops - p0, bytes_seen - b0, exp_q.size());
      end
      nack_addr = 1'b0;
      repeat (20) @(posedge mclk);
      #1;
      checks++;
      if (ctl.ACK_ERR !== 1'b1) begin failures++; $display("FAIL nack_sticky got=%b expected=1", ctl.ACK_ERR); end
   endtask

   task automatic test_clamp_busy();
      int cyc, s0, b0;
      bit extra;
      s0 = starts; b0 = bytes_seen;
      exp_q.push_back(8'h34); exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
      launch(7'h1A, 2'd3, 16'hA55A);
      checks++;
      if (ctl.ACK_ERR !== 1'b0) begin failures++; $display("FAIL clamp_ack_err_clear got=%b expected=0", ctl.ACK_ERR); end
      repeat (100) @(posedge mclk);
      #1;
      ctl.SLAVE_ADDR = 7'h7F;
      ctl.START      = 1'b1;
      @(posedge mclk); #1;
      ctl.START = 1'b0;
      wait_done(2000, cyc);
      checks++;
      if (cyc !== 351) begin failures++; $display("FAIL clamp_latency got=%0d expected=351", cyc); end
      extra = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(posedge mclk); #1;
         if (ctl.DONE !== 1'b0 || ctl.BUSY !== 1'b0) extra = 1'b1;
      end
      checks++;
      if (extra !== 1'b0) begin failures++; $display("FAIL busy_start_ignored got=%b expected=0", extra); end
      checks++;
      if (starts - s0 !== 1 || bytes_seen - b0 !== 3 || exp_q.size() !== 0) begin
         failures++;
         $display("FAIL clamp_framing got=%0d/%0d/%0d expected=1/3/0", starts - s0, bytes_seen - b0, exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int cyc, s0, p0, b0;
      exp_q.push_back(8'h56); exp_q.push_back(8'hC3); exp_q.push_back(8'h3C);
      launch(7'h2B, 2'd2, 16'hC33C);
      repeat (213) @(posedge mclk);
      #1;
      checks++;
      if ({scl, sda} !== 2'b00) begin failures++; $display("FAIL mid_pre_reset got=%b expected=00", {scl, sda}); end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({scl, sda, ctl.BUSY, ctl.DONE} !== 4'b1100) begin
         failures++; $display("FAIL mid_reset got=%b expected=1100", {scl, sda, ctl.BUSY, ctl.DONE});
      end
      @(posedge mclk); #1;
      reset_n = 1'b1;
      exp_q.delete();
      @(posedge mclk); #1;
      s0 = starts; p0 = stops; b0 = bytes_seen;
      exp_q.push_back(8'hA0); exp_q.push_back(8'h77);
      launch(7'h50, 2'd1, 16'hFF77);
      wait_done(2000, cyc);
      checks++;
      if (cyc !== 308) begin failures++; $display("FAIL after_reset_latency got=%0d expected=308", cyc); end
      checks++;
      if (starts - s0 !== 1 || stops - p0 !== 1 || bytes_seen - b0 !== 2 || exp_q.size() !== 0 || ctl.ACK_ERR !== 1'b0) begin
         failures++;
         $display("FAIL after_reset_framing got=%0d/%0d/%0d/%0d/%b expected=1/1/2/0/0",
                  starts - s0, stops - p0, bytes_seen - b0, exp_q.size(), ctl.ACK_ERR);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, s0, p0, b0;
      s0 = starts; p0 = stops; b0 = bytes_seen;
      exp_q.push_back(8'h78); exp_q.push_back(8'h78);
      ctl.SLAVE_ADDR = 7'h3C;
      ctl.NUM_BYTES  = 2'd0;
      ctl.DATA       = 16'hDEAD;
      ctl.START      = 1'b1;
      @(posedge mclk); #1;
      wait_done(2000, cyc);
      checks++;
      if (cyc !== 164) begin failures++; $display("FAIL probe_latency got=%0d expected=164", cyc); end
      @(posedge mclk); #1;
      ctl.START = 1'b0;
      checks++;
      if ({ctl.BUSY, ctl.DONE} !== 2'b10) begin
         failures++; $display("FAIL b2b_accept got=%b expected=10", {ctl.BUSY, ctl.DONE});
      end
      wait_done(2000, cyc);
      checks++;
      if (cyc !== 164) begin failures++; $display("FAIL b2b_latency got=%0d expected=164", cyc); end
      checks++;
      if (starts - s0 !== 2 || stops - p0 !== 2 || bytes_seen - b0 !== 2 || exp_q.size() !== 0) begin
         failures++;
         $display("FAIL b2b_framing got=%0d/%0d/%0d/%0d expected=2/2/2/0",
                  starts - s0, stops - p0, bytes_seen - b0, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_nack();
      test_clamp_busy();
      test_reset_mid();
      test_back_to_back();
      repeat (10) @(posedge mclk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/i2c_write_master.md
Name: i2c_write_master

Overview:
- Parametrised I2C write-only master; next generation of the fixed-length codec configuration serialiser.
- Sends START, a 7-bit slave address with W=0, then 0..MAX_BYTES data bytes MSB-first, then STOP.
- SCL runs at a divided MCLK rate instead of a gated MCLK. Each ACK slot is sampled and checked; a NACK aborts the transfer.
- Sits between the codec/peripheral init sequencer and the board I2C pins.

Parameters:
- CLK_DIV, 4, MCLK cycles per SCL quarter-period; legal range >= 3. SCL frequency = MCLK/(4*CLK_DIV).
- MAX_BYTES, 2, maximum data bytes per transfer.
- CNT_W, 2, width of NUM_BYTES; must satisfy 2^CNT_W > MAX_BYTES.

Ports:
- MCLK  input  1  system clock
- RESET  input  1  asynchronous active-low reset
- START  input  1  transfer request; sampled on MCLK rising edge
- SLAVE_ADDR  input  7  slave address; latched when START is accepted
- NUM_BYTES  input  CNT_W  data byte count; latched; values above MAX_BYTES are clamped to MAX_BYTES
- DATA  input  8*MAX_BYTES  payload; latched; first byte sent is DATA[8*N-1 -: 8], last byte is DATA[7:0] (N = latched count)
- BUSY  output  1  high while a transfer is in progress
- DONE  output  1  one-cycle pulse when a transfer ends, whether OK or NACK
- ACK_ERR  output  1  sticky NACK flag for the last transfer
- SCL  output  1  push-pull I2C clock
- SDA  inout  1  open-drain data: drive 0 or release to Z

Behaviour:
- Interface: reset RESET, asynchronous, active-low; clock MCLK.
- Reset values (asynchronous, also mid-transfer): SCL=1, SDA released (Z), BUSY=0, DONE=0, ACK_ERR=0, state IDLE, divider counter 0. After reset the next transfer starts cleanly.
- Quarter tick: a divider counter runs 0..CLK_DIV-1 while not IDLE. The FSM advances one quarter (q) per wrap.
- Acceptance: START=1 in IDLE is accepted on that edge. On acceptance: latch all inputs, BUSY=1, ACK_ERR=0. START while BUSY is ignored.
- States:
  - IDLE: SCL=1, SDA=Z.
  - START (2 quarters): q0 SDA=0 with SCL=1; q1 SCL=0.
  - BIT (4 quarters per bit): q0 SCL=0 and SDA set (0 drives low, 1 releases); q1 SCL=1; q2 SCL=1; q3 SCL=0. The address byte is {SLAVE_ADDR, 1'b0}, 8 bits, MSB first.
  - ACK (4 quarters): same SCL pattern as BIT with SDA released. The SDA input goes through a 2-flop synchroniser; the synchronised value is sampled on the last MCLK of q2. A sample of 1 sets ACK_ERR, and the transfer goes to STOP after this slot. A sample of 0 continues with the next byte, or goes to STOP after the last byte.
  - STOP (3 quarters): q0 SCL=0, SDA=0; q1 SCL=1; q2 SDA released. At the end of q2: DONE=1 for one cycle, BUSY=0, return to IDLE.
- Latency for N bytes, no NACK: DONE is asserted (2 + 36*(N+1) + 3)*CLK_DIV MCLK cycles after the accepting edge. A START presented in the DONE cycle is accepted.
- SDA transitions occur only while SCL=0, except for the START and STOP conditions.
- N=0 is an address-only probe: START, address, ACK, STOP.
- ACK_ERR holds its value until the next accepted START or a reset.

Test Plan:
- Reset release, no START -> SCL=1, SDA=Z, BUSY=0, DONE=0, ACK_ERR=0 indefinitely.
- CLK_DIV=4, SLAVE_ADDR=7'h1A, N=2, DATA=16'h1E00, slave model ACKs -> SDA bit stream 0x34, A, 0x1E, A, 0x00, A; valid START/STOP; DONE pulse at cycle 452; ACK_ERR=0.
- Same transfer, slave NACKs the address -> ACK_ERR=1, no data bits driven, STOP follows immediately, DONE at cycle (2+36+3)*4=164.
- NUM_BYTES=3 with MAX_BYTES=2 -> clamped to 2 bytes; START asserted while BUSY -> ignored, no second transfer.
- RESET asserted mid-data-byte -> SCL=1 and SDA=Z immediately; a new transfer after release completes normally.
- N=0 probe, ACK -> DONE at (2+36+3)*CLK_DIV; back-to-back START held high at DONE -> second transfer begins on that edge.
